// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetch requests, holds returned
// instructions in order, and discards responses made stale by a redirect.
module fetch_queue #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               DEPTH    = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        imem_req_valid,
    output logic [XLEN-1:0]             imem_req_addr,
    input  logic                        imem_req_ready,
    input  logic                        imem_resp_valid,
    input  logic [31:0]                 imem_resp_data,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_addr,
    output logic                        fd_valid,
    output logic [XLEN-1:0]             fd_pc,
    output logic [31:0]                 fd_instr,
    input  logic                        d_ready,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic                        proto_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW:0] DEPTH_W = (OW + 1)'(DEPTH);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; valid never waits on ready.
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic [OW-1:0]   unf_q, unf_d;
    logic [OW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW-1:0]   fill_q, fill_d;
    logic            proto_err_q, proto_err_d;
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];

    logic [OW:0] used;
    logic        accept;
    logic        drop_resp;
    logic        fill_en;
    logic        unexpected;
    logic        pop;

    assign used       = {1'b0, occ_q} + {1'b0, drop_q};
    assign accept     = imem_req_valid && imem_req_ready;
    assign drop_resp  = imem_resp_valid && (drop_q != '0);
    assign fill_en    = imem_resp_valid && (drop_q == '0) && (unf_q != '0);
    assign unexpected = imem_resp_valid && (drop_q == '0) && (unf_q == '0);
    assign pop        = fd_valid && d_ready;

    assign imem_req_valid = !reset && !redirect_valid && (used < DEPTH_W);
    assign imem_req_addr  = fetch_pc_q;
    // Entries fill in order, so the head is filled whenever some entry is.
    assign fd_valid       = (occ_q != unf_q);
    assign fd_pc          = pc_q[head_q];
    assign fd_instr       = instr_q[head_q];
    assign occupancy      = occ_q;
    assign proto_err      = proto_err_q;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        occ_d       = occ_q;
        unf_d       = unf_q;
        drop_d      = drop_q;
        head_d      = head_q;
        tail_d      = tail_q;
        fill_d      = fill_q;
        proto_err_d = proto_err_q | unexpected;
        if (redirect_valid) begin
            // A response arriving now counts as filled, so it is not re-dropped.
            fetch_pc_d = redirect_addr;
            occ_d      = '0;
            unf_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            drop_d     = drop_q - OW'(drop_resp) + unf_q - OW'(fill_en);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            occ_d  = occ_q + OW'(accept) - OW'(pop);
            unf_d  = unf_q + OW'(accept) - OW'(fill_en);
            drop_d = drop_q - OW'(drop_resp);
            head_d = head_q + PW'(pop);
            tail_d = tail_q + PW'(accept);
            fill_d = fill_q + PW'(fill_en);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            occ_q       <= '0;
            unf_q       <= '0;
            drop_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            occ_q       <= occ_d;
            unf_q       <= unf_d;
            drop_q      <= drop_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            proto_err_q <= proto_err_d;
            if (accept) begin
                pc_q[tail_q] <= fetch_pc_q;
            end
            if (fill_en) begin
                instr_q[fill_q] <= imem_resp_data;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model, expected-delivery scoreboard,
// directed scenarios followed by a randomised run.
module tb_fetch_queue;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic                   clock;
    logic                   reset;
    logic                   imem_req_valid;
    logic [XLEN-1:0]        imem_req_addr;
    logic                   imem_req_ready;
    logic                   imem_resp_valid;
    logic [31:0]            imem_resp_data;
    logic                   redirect_valid;
    logic [XLEN-1:0]        redirect_addr;
    logic                   fd_valid;
    logic [XLEN-1:0]        fd_pc;
    logic [31:0]            fd_instr;
    logic                   d_ready;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   proto_err;

    fetch_queue #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .fd_valid        (fd_valid),
        .fd_pc           (fd_pc),
        .fd_instr        (fd_instr),
        .d_ready         (d_ready),
        .occupancy       (occupancy),
        .proto_err       (proto_err)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // scoreboard state
    logic [63:0] exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] exp_fetch;
    logic [31:0] first_pc;
    int          n_cmp;
    int          n_err;
    int          acc_cnt;
    int          pop_cnt;
    bit          mem_en;
    bit          mem_rand;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: observe handshakes mid-cycle, then drive the memory
    // response for the following cycle.
    task automatic cycle();
        logic [63:0] e;
        logic [31:0] a;
        #2;
        if (reset) begin
            exp_q.delete();
            mem_q.delete();
            exp_fetch = RESET_PC;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", 64'(imem_req_addr), 64'(exp_fetch));
                exp_q.push_back({exp_fetch, mem_fn(exp_fetch)});
                mem_q.push_back(exp_fetch);
                acc_cnt++;
                exp_fetch = exp_fetch + 32'd4;
            end
            if (fd_valid && d_ready) begin
                check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("fd_pc", 64'(fd_pc), 64'(e[63:32]));
                    check("fd_instr", 64'(fd_instr), 64'(e[31:0]));
                end
                if (pop_cnt == 0) first_pc = fd_pc;
                pop_cnt++;
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_fetch = redirect_addr;
            end
        end
        @(posedge clock);
        #1;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mem_en && !reset && mem_q.size() != 0 && (!mem_rand || $urandom_range(0, 3) != 0)) begin
            a = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_fn(a);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; acc_cnt = 0; pop_cnt = 0;
        mem_en = 1'b0; mem_rand = 1'b0;
        exp_fetch = RESET_PC; first_pc = '0;
        reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = '0; redirect_valid = 1'b0; redirect_addr = '0;
        d_ready = 1'b0;

        // reset state, sampled while reset is still high
        reset = 1'b1;
        imem_req_ready = 1'b1;
        cycle();
        cycle();
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_fd_valid", 64'(fd_valid), 64'd0);
        check("rst_fd_pc", 64'(fd_pc), 64'd0);
        check("rst_fd_instr", 64'(fd_instr), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
        check("post_rst_req_valid", 64'(imem_req_valid), 64'd1);

        // streaming with 1-cycle memory and always-ready decode
        mem_en = 1'b1; d_ready = 1'b1;
        cycle();
        check("lat_not_yet", 64'(fd_valid), 64'd0);
        cycle();
        check("lat_fd_valid", 64'(fd_valid), 64'd1);
        check("lat_fd_pc", 64'(fd_pc), 64'h0);
        pop_cnt = 0;
        repeat (12) cycle();
        check("stream_pops", 64'(pop_cnt), 64'd12);

        // back-pressure fills the queue
        do_reset();
        d_ready = 1'b0; acc_cnt = 0;
        repeat (8) cycle();
        #1;
        check("full_accepts", 64'(acc_cnt), 64'd4);
        check("full_occupancy", 64'(occupancy), 64'd4);
        check("full_req_valid", 64'(imem_req_valid), 64'd0);
        d_ready = 1'b1;
        cycle();
        d_ready = 1'b0;
        #1;
        check("after_pop_req_valid", 64'(imem_req_valid), 64'd1);
        check("after_pop_req_addr", 64'(imem_req_addr), 64'h10);
        cycle();
        d_ready = 1'b1;
        repeat (10) cycle();

        // redirect with three unfilled requests in flight
        do_reset();
        mem_en = 1'b0; d_ready = 1'b1; imem_req_ready = 1'b1;
        repeat (3) cycle();
        redirect_valid = 1'b1; redirect_addr = 32'h100;
        cycle();
        check("redir_occupancy", 64'(occupancy), 64'd0);
        mem_en = 1'b1; pop_cnt = 0;
        repeat (14) cycle();
        check("redir_first_pc", 64'(first_pc), 64'h100);
        check("redir_proto_err", 64'(proto_err), 64'd0);

        // redirect coinciding with a response and a pop
        do_reset();
        mem_en = 1'b0; d_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (4) cycle();
        mem_en = 1'b1;
        cycle();
        cycle();
        mem_en = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h200; d_ready = 1'b1;
        pop_cnt = 0;
        cycle();
        check("coinc_popped", 64'(pop_cnt), 64'd1);
        check("coinc_occupancy", 64'(occupancy), 64'd0);
        check("coinc_fd_valid", 64'(fd_valid), 64'd0);
        d_ready = 1'b0; acc_cnt = 0;
        repeat (5) cycle();
        check("coinc_drop_room", 64'(acc_cnt), 64'd2);
        mem_en = 1'b1; d_ready = 1'b1; pop_cnt = 0;
        repeat (14) cycle();
        check("coinc_first_pc", 64'(first_pc), 64'h200);
        check("coinc_proto_err", 64'(proto_err), 64'd0);

        // unexpected response
        do_reset();
        imem_req_ready = 1'b0; mem_en = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        cycle();
        check("perr_set", 64'(proto_err), 64'd1);
        check("perr_fd_valid", 64'(fd_valid), 64'd0);
        repeat (3) cycle();
        check("perr_sticky", 64'(proto_err), 64'd1);
        check("perr_fd_valid_later", 64'(fd_valid), 64'd0);
        do_reset();
        check("perr_cleared", 64'(proto_err), 64'd0);

        // address wrap, then reset mid-stream
        redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        cycle();
        check("wrap_start_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
        imem_req_ready = 1'b1; mem_en = 1'b1; d_ready = 1'b1;
        cycle();
        check("wrap_next_addr", 64'(imem_req_addr), 64'h0);
        repeat (4) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("midrst_fd_valid", 64'(fd_valid), 64'd0);
        check("midrst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
        check("midrst_occupancy", 64'(occupancy), 64'd0);
        repeat (8) cycle();

        // randomised traffic with occasional redirects
        mem_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            d_ready        = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_addr  = $urandom() & 32'hFFFF_FFFC;
            end
            cycle();
        end
        mem_rand = 1'b0; imem_req_ready = 1'b0; d_ready = 1'b1;
        repeat (20) cycle();
        check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
        check("drain_occupancy", 64'(occupancy), 64'd0);
        check("drain_proto_err", 64'(proto_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_addr  output  XLEN  fetch address.
REQ-008 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port imem_resp_valid  input  1  instruction returned, in request order, >= 1 cycle after accept.
REQ-010 SHALL have port imem_resp_data  input  32  returned instruction.
REQ-011 SHALL have port redirect_valid  input  1  branch/flush request.
REQ-012 SHALL have port redirect_addr  input  XLEN  redirect target.
REQ-013 SHALL have port fd_valid  output  1  head entry holds a filled instruction.
REQ-014 SHALL have port fd_pc  output  XLEN  head PC.
REQ-015 SHALL have port fd_instr  output  32  head instruction.
REQ-016 SHALL have port d_ready  input  1  decode consumes head.
REQ-017 SHALL have port occupancy  output  clog2(DEPTH)+1  allocated entries.
REQ-018 SHALL have port proto_err  output  1  sticky unexpected-response flag.

Function
REQ-019 SHALL hold fetch_pc register; imem_req_addr = fetch_pc.
REQ-020 SHALL drive imem_req_valid = !redirect_valid && (occupancy + drop_cnt < DEPTH).
REQ-021 SHALL, on accept (imem_req_valid && imem_req_ready), allocate tail entry {pc=fetch_pc, filled=0} and set fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN.
REQ-022 SHALL, on imem_resp_valid with drop_cnt == 0, write imem_resp_data into oldest allocated unfilled entry and mark it filled.
REQ-023 SHALL drive fd_valid = head allocated && filled; fd_pc/fd_instr from head, directly from registers.
REQ-024 SHALL pop head when fd_valid && d_ready; lowest latency accept-to-fd_valid is resp cycle + 1.
REQ-025 SHALL allow allocate, fill and pop in the same cycle; occupancy += alloc - pop.
REQ-026 SHALL, on redirect_valid, next cycle: fetch_pc = redirect_addr, all entries deallocated, occupancy = 0, drop_cnt = number of allocated unfilled entries (a response in the redirect cycle counts as filled, i.e. discarded, and is not added).
REQ-027 SHALL treat a pop in the redirect cycle as delivered; no request accepted in that cycle.
REQ-028 SHALL, while drop_cnt > 0, discard each imem_resp_valid and decrement drop_cnt; new requests permitted subject to REQ-020.
REQ-029 SHALL set proto_err = 1 on imem_resp_valid when drop_cnt == 0 and no unfilled entry exists; data ignored; flag sticky until reset.
REQ-030 SHALL, when full (occupancy + drop_cnt == DEPTH), hold imem_req_valid low; fetch_pc unchanged.
REQ-031 SHALL keep head/tail/fill pointers as log2(DEPTH)-bit wrapping counters.

Reset
REQ-032 SHALL, in any cycle reset is high, next state: fetch_pc = RESET_PC, occupancy = 0, drop_cnt = 0, proto_err = 0, all entries invalid; fd_valid = 0, fd_pc = 0, fd_instr = 0.
REQ-033 SHALL give reset priority over redirect, request, response and pop, including mid-operation.
REQ-034 SHALL deassert imem_req_valid during reset cycle; requests resume the cycle after.

Verification
REQ-035 Reset, req_ready=1, 1-cycle memory, d_ready=1 -> requests 0x0,0x4,0x8...; fd_pc 0x0 then +4 per cycle, fd_instr matches memory.
REQ-036 d_ready=0, req_ready=1, DEPTH=4 -> exactly 4 accepts, occupancy=4, imem_req_valid=0; d_ready=1 for one cycle -> one pop, next accept addr 0x10.
REQ-037 3 requests in flight unfilled, redirect to 0x100 -> occupancy 0, 3 later responses discarded, first fd_pc=0x100 with its data, proto_err=0.
REQ-038 Redirect in same cycle as a response and a pop -> popped entry delivered, response discarded, drop_cnt = remaining unfilled.
REQ-039 imem_resp_valid with empty queue, drop_cnt=0 -> proto_err=1 sticky, fd_valid stays 0; reset clears it.
REQ-040 fetch_pc=0xFFFF_FFFC accepted -> next imem_req_addr = 0x0000_0000; reset mid-stream -> next request addr = RESET_PC, fd_valid=0.
